branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage counterpart of the IF-side branch predictor. It resolves each branch or jump in EX and compares the actual outcome against the prediction carried down the pipe.
- On a misprediction it issues a redirect and a global-BHR repair, then squashes wrong-path EX slots.
- Training records for conditional branches are buffered in a small FIFO that drains into the predictor tables' single write port.

Parameters:
- BHR_SIZE, 7: global branch history width; matches the predictor.
- QUEUE_DEPTH, 4: number of entries in the update FIFO; must be a power of 2 and at least 2.
- SQUASH_CYCLES, 2: number of EX slots ignored after a redirect (wrong-path flush window); must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- valid_branch_ex  in  1  a branch or jump occupies EX this cycle
- is_branch_ex  in  1  conditional branch
- is_jump_ex  in  1  jal/jalr
- cmp_out_ex  in  1  branch comparator result
- pc_ex  in  32  PC of the EX instruction
- branch_pc_ex  in  32  computed target
- predicted_pc_ex  in  32  next PC that fetch actually used
- bhr_ex  in  BHR_SIZE  BHR snapshot at the time of prediction
- glob_predict_taken_ex  in  1  global predictor's direction
- loc_predict_taken_ex  in  1  local predictor's direction
- stall_ex  out  1  EX must hold; update FIFO is full
- redirect  out  1  one-cycle flush/refetch pulse
- redirect_pc  out  32  correct next PC
- bhr_restore_valid  out  1  qualifies bhr_restore
- bhr_restore  out  BHR_SIZE  repaired global history
- upd_valid  out  1  head of FIFO is valid
- upd_ready  in  1  predictor table accepts the update
- upd_pc  out  32  PC of the update entry
- upd_bhr  out  BHR_SIZE  BHR snapshot of the update entry
- upd_taken  out  1  actual direction
- upd_glob_correct  out  1  global predictor was correct
- upd_loc_correct  out  1  local predictor was correct
- upd_chooser_en  out  1  glob_correct differs from loc_correct
- branch_cnt  out  32  resolved-branch counter
- mispredict_cnt  out  32  misprediction counter

Behaviour:
- Reset (rst=0, async):
  - All outputs, counters and FIFO pointers clear to 0; FSM enters RUN.
  - Reset mid-drain discards all queued updates.
- Accept condition: accept = valid_branch_ex & ~stall_ex & (state==RUN).
- actual_taken = is_jump_ex | (is_branch_ex & cmp_out_ex).
- actual_next = actual_taken ? branch_pc_ex : pc_ex+4, using 32-bit wrap-around add.
- mispredict = accept & (actual_next != predicted_pc_ex).
- Redirect timing:
  - redirect, redirect_pc and bhr_restore_valid are registered and assert exactly 1 cycle after the accepting cycle, for 1 cycle.
  - bhr_restore = {bhr_ex[BHR_SIZE-2:0], actual_taken} for branches; bhr_restore = bhr_ex for jumps, which are not recorded in history.
- FSM:
  - RUN: on mispredict go to SQUASH and load sq_cnt=SQUASH_CYCLES.
  - SQUASH: valid_branch_ex is ignored (no redirect, no enqueue, no count); sq_cnt decrements each cycle; return to RUN in the cycle after sq_cnt reaches 1.
  - A misprediction can therefore never be recognised while in SQUASH.
- Enqueue:
  - On accept & is_branch_ex, push {pc_ex, bhr_ex, actual_taken, glob==actual_taken, loc==actual_taken}.
  - Jumps only redirect; they are never enqueued.
- stall_ex:
  - Combinational; stall_ex = (count==QUEUE_DEPTH), even when a dequeue happens the same cycle (conservative).
  - While stalled, EX holds its inputs; nothing is accepted and no redirect is produced for that slot.
- Dequeue:
  - Occurs when upd_valid & upd_ready.
  - upd_* outputs are driven from the head entry, which is stable while upd_valid & ~upd_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
- upd_valid = (count != 0); an empty FIFO never presents an entry.
- branch_cnt increments per accepted branch or jump; mispredict_cnt increments per mispredict. Both wrap at 2^32.
- Latency: an entry enqueued at cycle N reaches upd_valid at the earliest in cycle N+1; there is no fall-through.

Decomposition:
- Shared package branch_pkg holds:
  - BHR_SIZE constant
  - bp_update_t struct (pc, bhr, taken, glob_correct, loc_correct)
  - resolve_state_e enum {RUN, SQUASH}
- One natural sub-module, bp_update_fifo: parameterised synchronous FIFO of bp_update_t with count, full and empty outputs.

Test Plan:
- Correct predictions:
  - Stimulus: branch, pc_ex=0x100, cmp=1, target=0x140, predicted=0x140, glob=1, loc=0.
  - Required: no redirect; next cycle upd_valid=1, upd_taken=1, glob_correct=1, loc_correct=0, chooser_en=1; branch_cnt=1.
- Not-taken mispredict:
  - Stimulus: branch, pc=0x200, cmp=0, predicted=0x240, bhr_ex=7'b0000001.
  - Required: 1 cycle later redirect=1, redirect_pc=0x204, bhr_restore=7'b0000010; mispredict_cnt=1.
- Squash window:
  - Stimulus: after the mispredict above, present mispredicting branches in the next 2 EX cycles.
  - Required: no redirect, no enqueue, counters unchanged; a 3rd-cycle mispredict does redirect.
- Jump mispredict:
  - Stimulus: jump, pc=0x300, target=0x800, predicted=0x304, bhr_ex=7'h55.
  - Required: redirect_pc=0x800, bhr_restore=7'h55; nothing enqueued.
- Full FIFO and backpressure:
  - Stimulus: upd_ready=0, enqueue 4 branches.
  - Required: stall_ex=1 and the 5th branch is not accepted.
  - Then raise upd_ready: entries drain in order, 1 per cycle; stall_ex drops when count goes 4→3; the 5th branch is accepted in that cycle.
- Async reset mid-drain:
  - Stimulus: drop rst with 3 entries queued and the FSM in SQUASH.
  - Required: immediately upd_valid=0, stall_ex=0, counters=0, state=RUN.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types for the EX-stage branch resolution slice
package branch_pkg;
    localparam int BHR_SIZE = 7;
    typedef struct packed {
        logic [31:0]         pc;
        logic [BHR_SIZE-1:0] bhr;
        logic                taken;
        logic                glob_correct;
        logic                loc_correct;
    } bp_update_t;
    typedef enum logic {RUN, SQUASH} resolve_state_e;
endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// bp_update_fifo: synchronous FIFO of predictor training records, no fall-through
module bp_update_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  bp_update_t    din,
    input  logic          pop,
    output bp_update_t    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    bp_update_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches, redirects on mispredict, queues predictor training
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int QUEUE_DEPTH   = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_branch_ex,
    input  logic                is_branch_ex,
    input  logic                is_jump_ex,
    input  logic                cmp_out_ex,
    input  logic [31:0]         pc_ex,
    input  logic [31:0]         branch_pc_ex,
    input  logic [31:0]         predicted_pc_ex,
    input  logic [BHR_SIZE-1:0] bhr_ex,
    input  logic                glob_predict_taken_ex,
    input  logic                loc_predict_taken_ex,
    output logic                stall_ex,
    output logic                redirect,
    output logic [31:0]         redirect_pc,
    output logic                bhr_restore_valid,
    output logic [BHR_SIZE-1:0] bhr_restore,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [31:0]         upd_pc,
    output logic [BHR_SIZE-1:0] upd_bhr,
    output logic                upd_taken,
    output logic                upd_glob_correct,
    output logic                upd_loc_correct,
    output logic                upd_chooser_en,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispredict_cnt
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int SW = $clog2(SQUASH_CYCLES + 1);
    resolve_state_e state;
    logic [SW-1:0] sq_cnt;
    logic [CW-1:0] count;
    logic full, empty, accept, actual_taken, mispredict;
    logic [31:0] actual_next;
    bp_update_t enq, head;
    assign stall_ex     = count == CW'(QUEUE_DEPTH);
    assign accept       = valid_branch_ex & ~stall_ex & (state == RUN);
    assign actual_taken = is_jump_ex | (is_branch_ex & cmp_out_ex);
    assign actual_next  = actual_taken ? branch_pc_ex : pc_ex + 32'd4;
    assign mispredict   = accept & (actual_next != predicted_pc_ex);
    assign enq = '{pc: pc_ex, bhr: bhr_ex, taken: actual_taken,
                   glob_correct: glob_predict_taken_ex == actual_taken,
                   loc_correct: loc_predict_taken_ex == actual_taken};
    bp_update_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept & is_branch_ex & ~full),
        .din   (enq),
        .pop   (upd_valid & upd_ready),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign upd_valid        = ~empty;
    assign upd_pc           = head.pc;
    assign upd_bhr          = head.bhr;
    assign upd_taken        = head.taken;
    assign upd_glob_correct = head.glob_correct;
    assign upd_loc_correct  = head.loc_correct;
    assign upd_chooser_en   = head.glob_correct ^ head.loc_correct;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= RUN;
            sq_cnt            <= '0;
            redirect          <= 1'b0;
            redirect_pc       <= '0;
            bhr_restore_valid <= 1'b0;
            bhr_restore       <= '0;
            branch_cnt        <= '0;
            mispredict_cnt    <= '0;
        end else begin
            redirect          <= mispredict;
            bhr_restore_valid <= mispredict;
            branch_cnt        <= branch_cnt + 32'(accept);
            mispredict_cnt    <= mispredict_cnt + 32'(mispredict);
            if (mispredict) begin
                redirect_pc <= actual_next;
                bhr_restore <= is_branch_ex ? {bhr_ex[BHR_SIZE-2:0], actual_taken} : bhr_ex;
            end
            if (state == RUN) begin
                if (mispredict) begin
                    state  <= SQUASH;
                    sq_cnt <= SW'(SQUASH_CYCLES);
                end
            end else begin
                sq_cnt <= sq_cnt - 1'b1;
                if (sq_cnt == SW'(1)) state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus backpressure and async-reset sequences
module tb_branch_resolve_unit;
    import branch_pkg::*;
    typedef struct {
        bit vld, br, jmp, cmp;
        logic [31:0] pc, tgt, pred;
        logic [6:0] bhr;
        bit glob, loc;
        bit e_rd;
        logic [31:0] e_rpc;
        logic [6:0] e_rbhr;
        bit e_uv;
        logic [31:0] e_upc;
        bit e_ut, e_gc, e_lc;
        logic [31:0] e_bc, e_mc;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic valid_branch_ex = 1'b0, is_branch_ex = 1'b0, is_jump_ex = 1'b0, cmp_out_ex = 1'b0;
    logic [31:0] pc_ex = '0, branch_pc_ex = '0, predicted_pc_ex = '0;
    logic [BHR_SIZE-1:0] bhr_ex = '0;
    logic glob_predict_taken_ex = 1'b0, loc_predict_taken_ex = 1'b0, upd_ready = 1'b1;
    logic stall_ex, redirect, bhr_restore_valid, upd_valid, upd_taken;
    logic upd_glob_correct, upd_loc_correct, upd_chooser_en;
    logic [31:0] redirect_pc, upd_pc, branch_cnt, mispredict_cnt;
    logic [BHR_SIZE-1:0] bhr_restore, upd_bhr;
    int n_cmp = 0, n_fail = 0;
    vec_t tv [12];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .valid_branch_ex(valid_branch_ex), .is_branch_ex(is_branch_ex),
        .is_jump_ex(is_jump_ex), .cmp_out_ex(cmp_out_ex), .pc_ex(pc_ex), .branch_pc_ex(branch_pc_ex),
        .predicted_pc_ex(predicted_pc_ex), .bhr_ex(bhr_ex), .glob_predict_taken_ex(glob_predict_taken_ex),
        .loc_predict_taken_ex(loc_predict_taken_ex), .stall_ex(stall_ex), .redirect(redirect),
        .redirect_pc(redirect_pc), .bhr_restore_valid(bhr_restore_valid), .bhr_restore(bhr_restore),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_bhr(upd_bhr),
        .upd_taken(upd_taken), .upd_glob_correct(upd_glob_correct), .upd_loc_correct(upd_loc_correct),
        .upd_chooser_en(upd_chooser_en), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        valid_branch_ex = x.vld; is_branch_ex = x.br; is_jump_ex = x.jmp; cmp_out_ex = x.cmp;
        pc_ex = x.pc; branch_pc_ex = x.tgt; predicted_pc_ex = x.pred; bhr_ex = x.bhr;
        glob_predict_taken_ex = x.glob; loc_predict_taken_ex = x.loc;
    endtask

    task automatic br_in(input logic [31:0] pc, input bit cmp, input logic [31:0] tgt,
                         input logic [31:0] pred, input logic [6:0] bhr);
        vec_t x;
        x = '{1'b1, 1'b1, 1'b0, cmp, pc, tgt, pred, bhr, 1'b0, 1'b0,
              1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        drive(x);
    endtask

    initial begin
        vec_t idle;
        tv[0]  = '{1'b1,1'b1,1'b0,1'b1, 32'h100,32'h140,32'h140, 7'h00, 1'b1,1'b0,
                   1'b0,32'h0,7'h00, 1'b1,32'h100,1'b1,1'b1,1'b0, 32'd1,32'd0};
        tv[1]  = '{1'b1,1'b1,1'b0,1'b0, 32'h200,32'h280,32'h240, 7'h01, 1'b1,1'b0,
                   1'b1,32'h204,7'h02, 1'b1,32'h200,1'b0,1'b0,1'b1, 32'd2,32'd1};
        tv[2]  = '{1'b1,1'b1,1'b0,1'b1, 32'h210,32'h400,32'h214, 7'h00, 1'b0,1'b0,
                   1'b0,32'h0,7'h00, 1'b0,32'h0,1'b0,1'b0,1'b0, 32'd2,32'd1};
        tv[3]  = '{1'b1,1'b1,1'b0,1'b1, 32'h220,32'h400,32'h224, 7'h00, 1'b0,1'b0,
                   1'b0,32'h0,7'h00, 1'b0,32'h0,1'b0,1'b0,1'b0, 32'd2,32'd1};
        tv[4]  = '{1'b1,1'b1,1'b0,1'b1, 32'h230,32'h400,32'h234, 7'h0F, 1'b0,1'b1,
                   1'b1,32'h400,7'h1F, 1'b1,32'h230,1'b1,1'b0,1'b1, 32'd3,32'd2};
        idle   = '{1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, 7'h00, 1'b0,1'b0,
                   1'b0,32'h0,7'h00, 1'b0,32'h0,1'b0,1'b0,1'b0, 32'd3,32'd2};
        tv[5]  = idle;
        tv[6]  = idle;
        tv[7]  = '{1'b1,1'b0,1'b1,1'b0, 32'h300,32'h800,32'h304, 7'h55, 1'b0,1'b0,
                   1'b1,32'h800,7'h55, 1'b0,32'h0,1'b0,1'b0,1'b0, 32'd4,32'd3};
        idle.e_bc = 32'd4; idle.e_mc = 32'd3;
        tv[8]  = idle;
        tv[9]  = idle;
        tv[10] = '{1'b1,1'b0,1'b1,1'b0, 32'h500,32'h600,32'h600, 7'h00, 1'b0,1'b0,
                   1'b0,32'h0,7'h00, 1'b0,32'h0,1'b0,1'b0,1'b0, 32'd5,32'd3};
        tv[11] = '{1'b1,1'b1,1'b0,1'b0, 32'hFFFFFFFC,32'h10,32'h0, 7'h7F, 1'b0,1'b0,
                   1'b0,32'h0,7'h00, 1'b1,32'hFFFFFFFC,1'b0,1'b1,1'b1, 32'd6,32'd3};

        step(); step();
        chk("reset redirect", 32'(redirect), 32'd0);
        chk("reset upd_valid", 32'(upd_valid), 32'd0);
        chk("reset stall", 32'(stall_ex), 32'd0);
        chk("reset branch_cnt", branch_cnt, 32'd0);
        chk("reset mispredict_cnt", mispredict_cnt, 32'd0);
        #2 rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tv[i]);
            step();
            chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(tv[i].e_rd));
            chk($sformatf("v%0d bhr_restore_valid", i), 32'(bhr_restore_valid), 32'(tv[i].e_rd));
            chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(tv[i].e_uv));
            chk($sformatf("v%0d branch_cnt", i), branch_cnt, tv[i].e_bc);
            chk($sformatf("v%0d mispredict_cnt", i), mispredict_cnt, tv[i].e_mc);
            chk($sformatf("v%0d stall", i), 32'(stall_ex), 32'd0);
            if (tv[i].e_rd) begin
                chk($sformatf("v%0d redirect_pc", i), redirect_pc, tv[i].e_rpc);
                chk($sformatf("v%0d bhr_restore", i), 32'(bhr_restore), 32'(tv[i].e_rbhr));
            end
            if (tv[i].e_uv) begin
                chk($sformatf("v%0d upd_pc", i), upd_pc, tv[i].e_upc);
                chk($sformatf("v%0d upd_bhr", i), 32'(upd_bhr), 32'(tv[i].bhr));
                chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(tv[i].e_ut));
                chk($sformatf("v%0d glob_correct", i), 32'(upd_glob_correct), 32'(tv[i].e_gc));
                chk($sformatf("v%0d loc_correct", i), 32'(upd_loc_correct), 32'(tv[i].e_lc));
                chk($sformatf("v%0d chooser_en", i), 32'(upd_chooser_en), 32'(tv[i].e_gc ^ tv[i].e_lc));
            end
        end

        drive(idle);
        step();
        chk("drain empty", 32'(upd_valid), 32'd0);
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            br_in(32'h1000 + 32'(16 * i), 1'b1, 32'h1040 + 32'(16 * i), 32'h1040 + 32'(16 * i), 7'h00);
            step();
        end
        chk("full stall", 32'(stall_ex), 32'd1);
        chk("full head", upd_pc, 32'h1000);
        br_in(32'h1040, 1'b1, 32'h1080, 32'h1080, 7'h00);
        step();
        chk("5th blocked stall", 32'(stall_ex), 32'd1);
        chk("5th blocked cnt", branch_cnt, 32'd10);
        chk("held head", upd_pc, 32'h1000);
        upd_ready = 1'b1;
        step();
        chk("stall drops", 32'(stall_ex), 32'd0);
        chk("drain 2nd", upd_pc, 32'h1010);
        chk("5th still pending", branch_cnt, 32'd10);
        step();
        chk("5th accepted", branch_cnt, 32'd11);
        chk("drain 3rd", upd_pc, 32'h1020);
        drive(idle);
        step();
        chk("drain 4th", upd_pc, 32'h1030);
        step();
        chk("drain 5th", upd_pc, 32'h1040);
        step();
        chk("drained", 32'(upd_valid), 32'd0);

        upd_ready = 1'b0;
        br_in(32'h2000, 1'b1, 32'h2100, 32'h2100, 7'h00); step();
        br_in(32'h2010, 1'b1, 32'h2100, 32'h2100, 7'h00); step();
        br_in(32'h2020, 1'b1, 32'h2100, 32'h2024, 7'h00); step();
        chk("pre-reset redirect", 32'(redirect), 32'd1);
        chk("pre-reset upd_valid", 32'(upd_valid), 32'd1);
        chk("pre-reset mispredict_cnt", mispredict_cnt, 32'd4);
        drive(idle);
        #3 rst = 1'b0;
        #1;
        chk("async upd_valid", 32'(upd_valid), 32'd0);
        chk("async stall", 32'(stall_ex), 32'd0);
        chk("async redirect", 32'(redirect), 32'd0);
        chk("async branch_cnt", branch_cnt, 32'd0);
        chk("async mispredict_cnt", mispredict_cnt, 32'd0);
        #1 rst = 1'b1;
        br_in(32'h3000, 1'b0, 32'h3100, 32'h3100, 7'h41);
        step();
        chk("post-reset redirect", 32'(redirect), 32'd1);
        chk("post-reset redirect_pc", redirect_pc, 32'h3004);
        chk("post-reset bhr_restore", 32'(bhr_restore), 32'h02);
        chk("post-reset upd_pc", upd_pc, 32'h3000);
        chk("post-reset branch_cnt", branch_cnt, 32'd1);
        drive(idle);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
